// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: two-stage valid/ready unsigned multiplier.
// Each transaction selects an exact, truncated or OR-compressed product.
// A wrapping counter tracks how many products have been delivered.
module approx_mult_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned K     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   z,
  output logic [1:0]           out_mode,
  output logic [CNT_W-1:0]     op_count
);

  typedef enum logic [1:0] {
    MODE_EXACT = 2'b00,
    MODE_TRUNC = 2'b01,
    MODE_ORC   = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_x;
  logic [WIDTH-1:0]     s1_y;
  logic [1:0]           s1_mode;

  logic                 s2_free;
  logic                 s1_free;

  logic [2*WIDTH-1:0]   exact;
  logic [2*WIDTH-1:0]   hi_sum;
  logic [2*WIDTH-1:0]   low_or;
  logic [2*WIDTH-1:0]   term;
  logic [2*WIDTH-1:0]   prod;

  // Handshake flow control: a stage is free when empty or draining this cycle
  always_comb begin
    s2_free  = !out_valid || out_ready;
    s1_free  = !s1_valid || s2_free;
    in_ready = s1_free;
  end

  // Product from S1 operands. Columns >= K are summed exactly; columns < K are
  // collected as a per-column OR, one bit per column, so no carries arise there.
  always_comb begin
    exact  = (2*WIDTH)'(s1_x) * (2*WIDTH)'(s1_y);
    hi_sum = '0;
    low_or = '0;
    term   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        term = (2*WIDTH)'(s1_x[i] & s1_y[j]) << (i + j);
        if (i + j >= K) begin
          hi_sum = hi_sum + term;
        end else begin
          low_or = low_or | term;
        end
      end
    end
    case (mode_e'(s1_mode))
      MODE_TRUNC: prod = hi_sum;
      MODE_ORC:   prod = hi_sum | low_or;
      default:    prod = exact;
    endcase
  end

  // S1: capture operands on input handshake, otherwise empty out when drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_mode  <= '0;
    end else if (s1_free) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x    <= x;
        s1_y    <= y;
        s1_mode <= mode;
      end
    end
  end

  // S2: load product from S1 when free; z/out_mode hold while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      z         <= '0;
      out_mode  <= '0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        z        <= prod;
        out_mode <= s1_mode;
      end
    end
  end

  // Delivered-product counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule
